// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: instruction-fetch stage.
// Generates the fetch PC and issues one outstanding request at a time to
// instruction memory. Returned words go into a small prefetch FIFO. An output
// register presents one instruction per cycle to decode. When no real
// instruction is available it presents a NOP with flush_out=1 so decode can
// insert a bubble.
// Optional build macro FETCH_BYPASS_EN: when the FIFO is empty and decode is
// not stalled, an acked word is written straight into the output register.
// This cuts the fetch latency from 2 cycles to 1.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        stall_in,
    input  logic        branch_taken_in,
    input  logic [31:0] branch_target_in,
    output logic        imem_req_out,
    output logic [31:0] imem_addr_out,
    input  logic        imem_ack_in,
    input  logic [31:0] imem_data_in,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic        instr_valid_out,
    output logic        flush_out
);

    localparam logic [31:0]      NOP     = 32'h0000_0013;
    localparam int               PTR_W   = $clog2(FIFO_DEPTH);
    localparam int               CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD} state_t;

    state_t            state_reg;
    logic [31:0]       fetch_pc_reg;
    logic              discard_reg;
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg;
    logic [31:0]       fifo_pc_mem    [FIFO_DEPTH];
    logic [31:0]       fifo_instr_mem [FIFO_DEPTH];

    logic              redirect;
    logic              ack_accept;
    logic              bypass;
    logic              push;
    logic              pop;
    logic [CNT_W-1:0]  count_next;
    logic [31:0]       target_aligned;
    logic [31:0]       pc_plus4;
    logic [31:0]       fetch_pc_next;

    // Decode of this cycle's events: redirect, accepted ack, FIFO push/pop and occupancy after the edge
    always_comb begin
        redirect       = branch_taken_in && (state_reg != S_IDLE);
        ack_accept     = imem_ack_in && (state_reg == S_REQ) && !discard_reg && !redirect;
`ifdef FETCH_BYPASS_EN
        bypass         = ack_accept && (count_reg == '0) && !stall_in;
`else
        bypass         = 1'b0;
`endif
        push           = ack_accept && !bypass;
        pop            = !redirect && !stall_in && (count_reg != '0);
        target_aligned = branch_target_in & 32'hFFFF_FFFC;
        pc_plus4       = fetch_pc_reg + 32'd4;
        fetch_pc_next  = ack_accept ? pc_plus4 : fetch_pc_reg;
        count_next     = count_reg;
        if (redirect) begin
            count_next = '0;
        end else if (push && !pop) begin
            count_next = count_reg + CNT_ONE;
        end else if (pop && !push) begin
            count_next = count_reg - CNT_ONE;
        end
    end

    // Fetch FSM: PC, discard flag and the registered memory request.
    // During a discard the stale address stays on the bus until its ack arrives.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_reg     <= S_IDLE;
            fetch_pc_reg  <= RESET_PC;
            discard_reg   <= 1'b0;
            imem_req_out  <= 1'b0;
            imem_addr_out <= RESET_PC;
        end else if (state_reg == S_IDLE) begin
            state_reg     <= S_REQ;
            imem_req_out  <= 1'b1;
            imem_addr_out <= fetch_pc_reg;
        end else if (redirect) begin
            fetch_pc_reg <= target_aligned;
            state_reg    <= S_REQ;
            imem_req_out <= 1'b1;
            if (imem_req_out && !imem_ack_in) begin
                discard_reg <= 1'b1;
            end else begin
                discard_reg   <= 1'b0;
                imem_addr_out <= target_aligned;
            end
        end else begin
            case (state_reg)
                S_REQ: begin
                    if (imem_ack_in) begin
                        discard_reg  <= 1'b0;
                        fetch_pc_reg <= fetch_pc_next;
                        if (count_next == DEPTH_C) begin
                            state_reg    <= S_HOLD;
                            imem_req_out <= 1'b0;
                        end else begin
                            imem_addr_out <= fetch_pc_next;
                        end
                    end
                end
                S_HOLD: begin
                    if (count_next != DEPTH_C) begin
                        state_reg     <= S_REQ;
                        imem_req_out  <= 1'b1;
                        imem_addr_out <= fetch_pc_reg;
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    // Prefetch storage: plain arrays, written at the tail and never reset
    always_ff @(posedge clk_in) begin
        if (push) begin
            fifo_pc_mem[wr_ptr_reg]    <= fetch_pc_reg;
            fifo_instr_mem[wr_ptr_reg] <= imem_data_in;
        end
    end

    // FIFO pointers and occupancy; a redirect empties the buffer
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (redirect) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
            count_reg <= count_next;
        end
    end

    // Output register towards decode: a redirect forces a bubble even under stall
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            instr_out       <= NOP;
            pc_out          <= RESET_PC;
            instr_valid_out <= 1'b0;
            flush_out       <= 1'b1;
        end else if (redirect) begin
            instr_out       <= NOP;
            instr_valid_out <= 1'b0;
            flush_out       <= 1'b1;
        end else if (!stall_in) begin
            if (bypass) begin
                instr_out       <= imem_data_in;
                pc_out          <= fetch_pc_reg;
                instr_valid_out <= 1'b1;
                flush_out       <= 1'b0;
            end else if (count_reg != '0) begin
                instr_out       <= fifo_instr_mem[rd_ptr_reg];
                pc_out          <= fifo_pc_mem[rd_ptr_reg];
                instr_valid_out <= 1'b1;
                flush_out       <= 1'b0;
            end else begin
                instr_out       <= NOP;
                instr_valid_out <= 1'b0;
                flush_out       <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: randomized self-checking bench for instr_fetch_unit.
// Two instances run side by side on shared control inputs:
//   - instance 0 uses the default RESET_PC with a depth-2 FIFO;
//   - instance 1 uses RESET_PC=FFFF_FFF8 with a depth-4 FIFO, to exercise PC wrap.
// Each instance has its own latency-randomized memory responder. A
// transaction-level model (PC arithmetic plus an ordered instruction queue)
// predicts every output on every cycle.
module tb_instr_fetch_unit;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] RPC0 = 32'h0000_0000;
    localparam logic [31:0] RPC1 = 32'hFFFF_FFF8;
    localparam int          D0   = 2;
    localparam int          D1   = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        br = 1'b0;
    logic [31:0] tgt = 32'h0;
    logic        ack     [2];
    logic [31:0] rdata   [2];
    logic        req_o   [2];
    logic [31:0] addr_o  [2];
    logic [31:0] instr_o [2];
    logic [31:0] pc_o    [2];
    logic        valid_o [2];
    logic        flush_o [2];

    int checks   = 0;
    int failures = 0;

    // reference model state, per instance
    bit          m_act   [2];
    logic [31:0] m_fpc   [2];
    logic [31:0] m_held  [2];
    bit          m_disc  [2];
    logic [31:0] m_qpc   [2][8];
    logic [31:0] m_qins  [2][8];
    int          m_qn    [2];
    logic [31:0] m_instr [2];
    logic [31:0] m_pc    [2];
    bit          m_valid [2];
    int          depth   [2];
    logic [31:0] rpc     [2];

    // memory responder state, per instance
    bit          mem_pend [2];
    logic [31:0] mem_addr [2];
    int          mem_wait [2];
    int          mem_lat  [2];
    int          lat_min = 1;
    int          lat_max = 1;

    always #5 clk = ~clk;

    instr_fetch_unit #(.RESET_PC(RPC0), .FIFO_DEPTH(D0)) u_dut0 (
        .clk_in(clk), .rst_in(rst), .stall_in(stall),
        .branch_taken_in(br), .branch_target_in(tgt),
        .imem_req_out(req_o[0]), .imem_addr_out(addr_o[0]),
        .imem_ack_in(ack[0]), .imem_data_in(rdata[0]),
        .instr_out(instr_o[0]), .pc_out(pc_o[0]),
        .instr_valid_out(valid_o[0]), .flush_out(flush_o[0])
    );

    instr_fetch_unit #(.RESET_PC(RPC1), .FIFO_DEPTH(D1)) u_dut1 (
        .clk_in(clk), .rst_in(rst), .stall_in(stall),
        .branch_taken_in(br), .branch_target_in(tgt),
        .imem_req_out(req_o[1]), .imem_addr_out(addr_o[1]),
        .imem_ack_in(ack[1]), .imem_data_in(rdata[1]),
        .instr_out(instr_o[1]), .pc_out(pc_o[1]),
        .instr_valid_out(valid_o[1]), .flush_out(flush_o[1])
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%08h expected=%08h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset(input int i);
        m_act[i]    = 1'b0;
        m_fpc[i]    = rpc[i];
        m_held[i]   = rpc[i];
        m_disc[i]   = 1'b0;
        m_qn[i]     = 0;
        m_instr[i]  = NOP;
        m_pc[i]     = rpc[i];
        m_valid[i]  = 1'b0;
        mem_pend[i] = 1'b0;
        mem_wait[i] = 0;
    endtask

    // A request is up whenever fetch is running and the buffer has room.
    // The bus address is the stale one while a dropped response is awaited.
    task automatic check_outputs(input int i);
        bit exp_req;
        exp_req = m_act[i] && (m_qn[i] < depth[i]);
        check_eq($sformatf("req%0d", i), 32'(req_o[i]), 32'(exp_req));
        if (exp_req || !m_act[i])
            check_eq($sformatf("addr%0d", i), addr_o[i], m_disc[i] ? m_held[i] : m_fpc[i]);
        check_eq($sformatf("instr%0d", i), instr_o[i], m_instr[i]);
        check_eq($sformatf("pc%0d", i), pc_o[i], m_pc[i]);
        check_eq($sformatf("valid%0d", i), 32'(valid_o[i]), 32'(m_valid[i]));
        check_eq($sformatf("flush%0d", i), 32'(flush_o[i]), 32'(!m_valid[i]));
    endtask

    // Advance the model by one clock edge, using the inputs driven this cycle
    task automatic model_step(input int i, input bit a, input logic [31:0] d);
        bit          exp_req;
        bit          redir;
        bit          acc;
        bit          byp;
        logic [31:0] cur_addr;
        exp_req  = m_act[i] && (m_qn[i] < depth[i]);
        cur_addr = m_disc[i] ? m_held[i] : m_fpc[i];
        redir    = br && m_act[i];
        acc      = a && !m_disc[i] && !redir;
        byp      = 1'b0;
`ifdef FETCH_BYPASS_EN
        byp      = acc && (m_qn[i] == 0) && !stall;
`endif
        if (redir) begin
            m_instr[i] = NOP;
            m_valid[i] = 1'b0;
        end else if (!stall) begin
            if (byp) begin
                m_instr[i] = d;
                m_pc[i]    = m_fpc[i];
                m_valid[i] = 1'b1;
            end else if (m_qn[i] > 0) begin
                m_instr[i] = m_qins[i][0];
                m_pc[i]    = m_qpc[i][0];
                m_valid[i] = 1'b1;
                for (int k = 0; k < 7; k++) begin
                    m_qins[i][k] = m_qins[i][k+1];
                    m_qpc[i][k]  = m_qpc[i][k+1];
                end
                m_qn[i]--;
            end else begin
                m_instr[i] = NOP;
                m_valid[i] = 1'b0;
            end
        end
        if (acc && !byp) begin
            m_qpc[i][m_qn[i]]  = m_fpc[i];
            m_qins[i][m_qn[i]] = d;
            m_qn[i]++;
        end
        if (redir) begin
            if (exp_req && !a) begin
                m_held[i] = cur_addr;
                m_disc[i] = 1'b1;
            end else begin
                m_disc[i] = 1'b0;
            end
            m_fpc[i] = tgt & 32'hFFFF_FFFC;
            m_qn[i]  = 0;
        end else begin
            if (a) m_disc[i] = 1'b0;
            if (acc) m_fpc[i] = m_fpc[i] + 32'd4;
        end
        m_act[i] = 1'b1;
    endtask

    // One clock cycle, entered and left at a falling edge.
    // mode: 0 = hold responses back, 1 = respond after the chosen latency, 2 = respond now.
    task automatic run_cycle(input bit stall_v, input bit br_v, input logic [31:0] tgt_v, input int mode);
        for (int i = 0; i < 2; i++) check_outputs(i);
        stall = stall_v;
        br    = br_v;
        tgt   = tgt_v;
        for (int i = 0; i < 2; i++) begin
            ack[i] = 1'b0;
            if (req_o[i] && !mem_pend[i]) begin
                mem_pend[i] = 1'b1;
                mem_addr[i] = addr_o[i];
                mem_wait[i] = 0;
                mem_lat[i]  = $urandom_range(lat_max, lat_min);
            end
            if (mem_pend[i]) begin
                if (mode == 2 || (mode == 1 && mem_wait[i] >= mem_lat[i])) ack[i] = 1'b1;
                else mem_wait[i]++;
            end
            if (ack[i]) begin
                rdata[i]    = mem_addr[i] ^ 32'hA5A5_0000;
                mem_pend[i] = 1'b0;
                check_eq($sformatf("ack_has_req%0d", i), 32'(req_o[i]), 32'd1);
                $display("fetch dut%0d addr=%08h data=%08h stall=%0b br=%0b", i, mem_addr[i], rdata[i], stall, br);
            end
            model_step(i, ack[i], rdata[i]);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        stall  = 1'b0;
        br     = 1'b0;
        ack[0] = 1'b0;
        ack[1] = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            model_reset(i);
            check_outputs(i);
        end
        rst = 1'b0;
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        bit found;
        depth[0] = D0;  depth[1] = D1;
        rpc[0]   = RPC0; rpc[1]  = RPC1;
        rdata[0] = 32'h0; rdata[1] = 32'h0;
        ack[0]   = 1'b0;  ack[1]   = 1'b0;

        // reset, then streaming with next-cycle responses
        do_reset();
        lat_min = 1; lat_max = 1;
        repeat (30) run_cycle(1'b0, 1'b0, 32'h0, 1);

        // downstream stall for 5 cycles mid-stream, then resume
        repeat (5) run_cycle(1'b1, 1'b0, 32'h0, 1);
        repeat (10) run_cycle(1'b0, 1'b0, 32'h0, 1);

        // redirect to 0x102 while the request to 0x10 is outstanding
        do_reset();
        found = 1'b0;
        for (int n = 0; n < 200 && !found; n++) begin
            if (req_o[0] && addr_o[0] == 32'h10) found = 1'b1;
            else run_cycle(1'b0, 1'b0, 32'h0, 1);
        end
        check_eq("reach_req_0x10", 32'(found), 32'd1);
        run_cycle(1'b0, 1'b1, 32'h0000_0102, 0);
        repeat (12) run_cycle(1'b0, 1'b0, 32'h0, 1);

        // redirect in the same cycle as an ack, under stall
        found = 1'b0;
        for (int n = 0; n < 50 && !found; n++) begin
            if (req_o[0]) found = 1'b1;
            else run_cycle(1'b0, 1'b0, 32'h0, 1);
        end
        check_eq("reach_req_any", 32'(found), 32'd1);
        run_cycle(1'b1, 1'b1, 32'h0000_0200, 2);
        repeat (12) run_cycle(1'b0, 1'b0, 32'h0, 1);

        // randomized traffic: stalls, redirects, variable memory latency
        lat_min = 0; lat_max = 3;
        for (int n = 0; n < 400; n++) begin
            bit          s_v;
            bit          b_v;
            logic [31:0] t_v;
            s_v = ($urandom_range(99) < 30);
            b_v = ($urandom_range(99) < 6);
            t_v = ($urandom_range(1) == 1) ? ($urandom & 32'h0000_0FFF)
                                           : (32'hFFFF_FFF0 + 32'($urandom_range(15)));
            run_cycle(s_v, b_v, t_v, 1);
        end

        // asynchronous reset while a request is outstanding
        found = 1'b0;
        for (int n = 0; n < 50 && !found; n++) begin
            if (req_o[0] && req_o[1]) found = 1'b1;
            else run_cycle(1'b0, 1'b0, 32'h0, 1);
        end
        check_eq("reach_req_both", 32'(found), 32'd1);
        #1 rst = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            model_reset(i);
            check_outputs(i);
        end
        do_reset();
        lat_min = 1; lat_max = 1;
        repeat (20) run_cycle(1'b0, 1'b0, 32'h0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
